// File: rtl/strait_sel_scheduler.sv
// Row mux-select sequencer: LEFT streaming, SKEW thermometer ramp, DRAIN.
// Define STRAIT_SEL_STATUS_EN to enable the busy-cycle counter on cyc_cnt.
module strait_sel_scheduler #(
  parameter int ROWS  = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             stall,
  input  logic             abort,
  output logic [ROWS-1:0]  sel,
  output logic             busy,
  output logic             done,
  output logic [15:0]      cyc_cnt
);

  localparam int RW = $clog2(ROWS) + 1;
  localparam int CW = (LEN_W > RW) ? LEN_W : RW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEFT,
    S_SKEW,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_n;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_n;
  logic [LEN_W-1:0]  r_len;
  logic [ROWS-1:0]   r_sel;
  logic [ROWS-1:0]   w_sel_n;
  logic              w_accept;
  logic              w_busy;
  logic              w_last_left;
  logic              w_last_row;

  assign w_busy      = (r_state == S_LEFT) || (r_state == S_SKEW) ||
                       (r_state == S_DRAIN);
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_last_left = (r_cnt == CW'(r_len) - CW'(1));
  assign w_last_row  = (r_cnt == CW'(ROWS - 1));

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    if (w_busy && abort) begin
      w_state_n = S_IDLE;
      w_cnt_n   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            w_cnt_n   = '0;
            w_state_n = (len == '0) ? S_DONE : S_LEFT;
          end
        end
        S_LEFT: begin
          if (!stall) begin
            if (w_last_left) begin
              w_state_n = S_SKEW;
              w_cnt_n   = '0;
            end else begin
              w_cnt_n = r_cnt + CW'(1);
            end
          end
        end
        S_SKEW: begin
          if (!stall) begin
            if (w_last_row) begin
              w_state_n = S_DRAIN;
              w_cnt_n   = '0;
            end else begin
              w_cnt_n = r_cnt + CW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (!stall) begin
            if (w_last_row) begin
              w_state_n = S_DONE;
              w_cnt_n   = '0;
            end else begin
              w_cnt_n = r_cnt + CW'(1);
            end
          end
        end
        S_DONE: begin
          w_state_n = S_IDLE;
        end
        default: begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
        end
      endcase
    end
  end

  // sel is registered from the next state so it lines up with that state
  always_comb begin
    w_sel_n = '0;
    if (w_state_n == S_SKEW) begin
      for (int r = 0; r < ROWS; r++) begin
        w_sel_n[r] = (CW'(r) <= w_cnt_n);
      end
    end else if (w_state_n == S_DRAIN) begin
      w_sel_n = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_sel   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_sel   <= w_sel_n;
      if (w_accept) begin
        r_len <= len;
      end
    end
  end

  assign sel  = r_sel;
  assign busy = w_busy;
  assign done = (r_state == S_DONE);

`ifdef STRAIT_SEL_STATUS_EN
  logic [15:0] r_cyc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc <= '0;
    end else if (w_accept) begin
      r_cyc <= '0;
    end else if (w_busy && (r_cyc != 16'hFFFF)) begin
      r_cyc <= r_cyc + 16'd1;
    end
  end

  assign cyc_cnt = r_cyc;
`else
  assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_strait_sel_scheduler.sv
// Directed bench for strait_sel_scheduler (ROWS=4, LEN_W=8).
// Expected cyc_cnt follows whether STRAIT_SEL_STATUS_EN is defined.
module tb_strait_sel_scheduler;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] len;
  logic       stall;
  logic       abort;
  logic [3:0] sel;
  logic       busy;
  logic       done;
  logic [15:0] cyc_cnt;

  int n_tests;
  int n_fail;

  strait_sel_scheduler #(
    .ROWS (4),
    .LEN_W(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .len    (len),
    .stall  (stall),
    .abort  (abort),
    .sel    (sel),
    .busy   (busy),
    .done   (done),
    .cyc_cnt(cyc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] cyc_exp(input int n);
`ifdef STRAIT_SEL_STATUS_EN
    return 16'(n);
`else
    return 16'd0;
`endif
  endfunction

  task automatic chk(input string tag, input logic [3:0] s_e,
                     input logic b_e, input logic d_e);
    n_tests++;
    assert (sel === s_e) else begin
      n_fail++;
      $error("FAIL %s sel obs=%b exp=%b", tag, sel, s_e);
    end
    n_tests++;
    assert (busy === b_e) else begin
      n_fail++;
      $error("FAIL %s busy obs=%b exp=%b", tag, busy, b_e);
    end
    n_tests++;
    assert (done === d_e) else begin
      n_fail++;
      $error("FAIL %s done obs=%b exp=%b", tag, done, d_e);
    end
  endtask

  task automatic chk_cyc(input string tag, input logic [15:0] e);
    n_tests++;
    assert (cyc_cnt === e) else begin
      n_fail++;
      $error("FAIL %s cyc_cnt obs=%0d exp=%0d", tag, cyc_cnt, e);
    end
  endtask

  // Expected outputs in unstalled pass cycle i (1-based) for length l
  task automatic chk_pass(input string tag, input int i, input int l);
    logic [3:0] s;
    logic [3:0] therm [4];
    therm[0] = 4'b0001;
    therm[1] = 4'b0011;
    therm[2] = 4'b0111;
    therm[3] = 4'b1111;
    if (i <= l)          s = 4'b0000;
    else if (i <= l + 4) s = therm[i - l - 1];
    else if (i <= l + 8) s = 4'b1111;
    else                 s = 4'b0000;
    chk($sformatf("%s_c%0d", tag, i), s, i <= l + 8, i == l + 9);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst   = 1'b1;
    start = 1'b0;
    len   = 8'd0;
    stall = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset", 4'b0000, 1'b0, 1'b0);
    chk_cyc("reset", 16'd0);

    // Basic pass len=3
    start = 1'b1;
    len   = 8'd3;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      chk_pass("basic", i, 3);
      tick();
    end
    chk("basic_idle", 4'b0000, 1'b0, 1'b0);
    chk_cyc("basic", cyc_exp(11));

    // Stall two cycles while sel=0011
    start = 1'b1;
    len   = 8'd3;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      int j;
      j = (i <= 5) ? i : ((i <= 7) ? 5 : i - 2);
      chk_pass("stall", j, 3);
      stall = (i == 5) || (i == 6);
      tick();
    end
    stall = 1'b0;
    chk("stall_idle", 4'b0000, 1'b0, 1'b0);
    chk_cyc("stall", cyc_exp(13));

    // Abort in second DRAIN cycle, with stall also high
    start = 1'b1;
    len   = 8'd3;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      chk_pass("abort", i, 3);
      if (i == 9) begin
        abort = 1'b1;
        stall = 1'b1;
      end
      tick();
    end
    abort = 1'b0;
    stall = 1'b0;
    chk("abort_next", 4'b0000, 1'b0, 1'b0);
    chk_cyc("abort", cyc_exp(9));
    tick();
    chk("abort_nodone", 4'b0000, 1'b0, 1'b0);

    // New start after abort, len=1
    start = 1'b1;
    len   = 8'd1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      chk_pass("len1", i, 1);
      tick();
    end
    chk("len1_idle", 4'b0000, 1'b0, 1'b0);
    chk_cyc("len1", cyc_exp(9));

    // len=0 goes straight to DONE
    start = 1'b1;
    len   = 8'd0;
    tick();
    start = 1'b0;
    chk("len0_done", 4'b0000, 1'b0, 1'b1);
    chk_cyc("len0", 16'd0);
    tick();
    chk("len0_idle", 4'b0000, 1'b0, 1'b0);

    // Reset in LEFT cycle 2 with start held high
    start = 1'b1;
    len   = 8'd5;
    tick();
    chk("rst_c1", 4'b0000, 1'b1, 1'b0);
    tick();
    chk("rst_c2", 4'b0000, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_after", 4'b0000, 1'b0, 1'b0);
    chk_cyc("rst_after", 16'd0);

    // start held and len changed mid-pass are ignored
    len = 8'd2;
    tick();
    len = 8'd7;
    for (int i = 1; i <= 11; i++) begin
      chk_pass("held", i, 2);
      if (i == 11) start = 1'b0;
      tick();
    end
    chk("held_idle", 4'b0000, 1'b0, 1'b0);
    chk_cyc("held", cyc_exp(10));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/strait_sel_scheduler.md
STRAIT_SEL_SCHEDULER -- requirements
Module: strait_sel_scheduler

Interface
REQ-001 Parameter ROWS, default 4: number of P-input muxes (array rows) driven; legal range 1..16.
REQ-002 Parameter LEN_W, default 8: width of the streaming-length operand.
REQ-003 Clock and reset SHALL be one clock, clk, and reset rst, which is synchronous and active-high; all state changes on clk rising edge.
REQ-004 clk  input  1  system clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 start  input  1  request a new pass; sampled only in IDLE.
REQ-007 len  input  LEN_W  number of from_left streaming cycles; sampled with accepted start.
REQ-008 stall  input  1  freeze sequencing while high.
REQ-009 abort  input  1  cancel the current pass.
REQ-010 sel  output  ROWS  per-row mux select, registered; bit r=0 picks from_left, 1 picks from_top.
REQ-011 busy  output  1  high in LEFT, SKEW, DRAIN.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 cyc_cnt  output  16  busy-cycle count (see Configuration).

Function
REQ-014 States SHALL be IDLE, LEFT, SKEW, DRAIN, DONE, with a single internal counter cnt of max(LEN_W, clog2(ROWS)+1) bits.
REQ-015 IDLE: sel=0, busy=0, done=0. start=1 with len!=0 SHALL latch len, clear cnt, go to LEFT; start=1 with len==0 SHALL go directly to DONE.
REQ-016 LEFT: sel=all 0 for exactly len unstalled cycles; at cnt==len-1 go to SKEW, cnt cleared.
REQ-017 SKEW: in SKEW cycle k (k=0..ROWS-1) sel SHALL be thermometer code with bits 0..k set; after k=ROWS-1 go to DRAIN, cnt cleared.
REQ-018 DRAIN: sel=all 1 for exactly ROWS unstalled cycles, then go to DONE.
REQ-019 DONE: done=1, busy=0, sel=0 for one cycle, then IDLE unconditionally.
REQ-020 Latency: start accepted at edge t, first LEFT cycle is t+1, done high in cycle t+1+len+2*ROWS.
REQ-021 stall=1 in LEFT/SKEW/DRAIN SHALL hold state, cnt and sel; busy stays 1; stall ignored in IDLE and DONE.
REQ-022 abort=1 in LEFT/SKEW/DRAIN SHALL go to IDLE next cycle with sel=0 and no done pulse; abort has priority over stall; ignored in IDLE/DONE.
REQ-023 start while not in IDLE SHALL be ignored and not queued; len changes mid-pass SHALL have no effect.
REQ-024 ROWS=1: SKEW and DRAIN each last one cycle.

Reset
REQ-025 rst=1 SHALL force IDLE, cnt=0, sel=0, busy=0, done=0, cyc_cnt=0 at the next edge, overriding all inputs including mid-pass; no done pulse is generated.

Configuration
REQ-026 Macro STRAIT_SEL_STATUS_EN defined: cyc_cnt SHALL clear to 0 on accepted start, increment each cycle busy=1 (stalled cycles included), saturate at 0xFFFF, and hold after the pass until the next accepted start.
REQ-027 Macro STRAIT_SEL_STATUS_EN undefined: cyc_cnt SHALL be constant 0 with no counter logic; all other behaviour identical.

Verification
REQ-028 ROWS=4, len=3, start at edge t -> sel 0000 for cycles t+1..t+3, 0001/0011/0111/1111 for t+4..t+7, 1111 for t+8..t+11, done=1 only in t+12, cyc_cnt=11 afterwards (macro on).
REQ-029 Same pass with stall=1 for 2 cycles during SKEW at sel=0011 -> sel held at 0011 for 3 cycles total, done in t+14, cyc_cnt=13.
REQ-030 abort=1 in the second DRAIN cycle -> next cycle sel=0000, busy=0, no done pulse; new start then accepted normally.
REQ-031 start with len=0 -> done=1 the next cycle, busy never asserted, sel stays 0000.
REQ-032 rst=1 in LEFT cycle 2 -> next cycle IDLE, all outputs 0; start held high during pass is ignored until IDLE.
REQ-033 Build without STRAIT_SEL_STATUS_EN, repeat REQ-028 -> identical sel/busy/done trace, cyc_cnt=0 throughout.
